// File: rtl/noc_control_module_dii_arbiter.sv
// noc_control_module_dii_arbiter: packet-atomic round-robin merge of N_IN dii_flit streams.
// A 2-entry FIFO registers the output and keeps throughput at one flit per cycle.
package dii_pkg;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module noc_control_module_dii_arbiter
  import dii_pkg::*;
#(
  parameter int N_IN           = 2,
  parameter int MAX_DI_PKT_LEN = 12
) (
  input  logic                    clk,
  input  logic                    rst_debug,
  input  dii_flit                 in_flit [N_IN],
  output logic [N_IN-1:0]         in_ready,
  output dii_flit                 out_flit,
  input  logic                    out_ready,
  output logic [$clog2(N_IN)-1:0] grant_idx,
  output logic                    len_error
);
  localparam int IW = $clog2(N_IN);
  localparam int CW = $clog2(MAX_DI_PKT_LEN + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_rr, r_grant, w_sel, w_src;
  logic [CW-1:0]   r_flit_cnt, w_cnt_nxt;
  logic [16:0]     r_mem [2];
  logic            r_rd, r_wr;
  logic [1:0]      r_cnt;
  logic            w_any, w_space, w_act, w_push, w_pop, w_wd, w_last;
  // Scan downwards so the candidate closest to r_rr is the one left in w_sel.
  always_comb begin
    w_sel = r_rr;
    w_any = 1'b0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (in_flit[(int'(r_rr) + k) % N_IN].valid) begin
        w_sel = IW'((int'(r_rr) + k) % N_IN);
        w_any = 1'b1;
      end
    end
  end
  // Reset gates in_ready combinationally so no input sees an accept while held in reset.
  always_comb begin
    w_space     = r_cnt != 2'd2;
    w_src       = (r_state == IDLE) ? w_sel : r_grant;
    w_act       = !rst_debug && w_space && (r_state == LOCKED || w_any);
    in_ready    = w_act ? N_IN'(1) << w_src : '0;
    w_push      = w_act && in_flit[w_src].valid;
    w_cnt_nxt   = (r_state == IDLE) ? CW'(1) : r_flit_cnt + 1'b1;
    w_wd        = w_push && !in_flit[w_src].last && w_cnt_nxt == CW'(MAX_DI_PKT_LEN);
    w_last      = in_flit[w_src].last || w_wd;
    w_state_nxt = !w_push ? r_state : w_last ? IDLE : LOCKED;
    w_pop       = r_cnt != 2'd0 && out_ready;
  end
  always_ff @(posedge clk or posedge rst_debug)
    if (rst_debug) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_ff @(posedge clk or posedge rst_debug) begin
    if (rst_debug) begin
      r_rr       <= '0;
      r_grant    <= '0;
      r_flit_cnt <= '0;
      len_error  <= 1'b0;
    end else if (w_push) begin
      r_grant    <= w_src;
      r_flit_cnt <= w_cnt_nxt;
      if (w_last) r_rr <= (w_src == IW'(N_IN - 1)) ? '0 : w_src + 1'b1;
      if (w_wd) len_error <= 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst_debug) begin
    if (rst_debug) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {w_last, in_flit[w_src].data};
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
  assign out_flit.valid = r_cnt != 2'd0;
  assign out_flit.last  = r_mem[r_rd][16];
  assign out_flit.data  = r_mem[r_rd][15:0];
  assign grant_idx      = r_grant;
endmodule

// File: tb/tb_noc_control_module_dii_arbiter.sv
// tb_noc_control_module_dii_arbiter: directed checks of arbitration order, backpressure, watchdog and async reset.
module tb_noc_control_module_dii_arbiter;
  import dii_pkg::*;
  logic        clk = 1'b0;
  logic        rst_debug = 1'b0;
  logic        out_ready = 1'b0;
  dii_flit     in_flit [2];
  dii_flit     out_flit;
  logic [1:0]  in_ready;
  logic [0:0]  grant_idx;
  logic        len_error;
  logic [16:0] src_q [2][$];
  logic        en [2];
  logic [16:0] obs[$], exp_q[$];
  int          n_chk = 0, n_err = 0, cyc;

  noc_control_module_dii_arbiter #(.N_IN(2), .MAX_DI_PKT_LEN(12)) dut (
    .clk(clk), .rst_debug(rst_debug), .in_flit(in_flit), .in_ready(in_ready),
    .out_flit(out_flit), .out_ready(out_ready), .grant_idx(grant_idx), .len_error(len_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      in_flit[i].valid = en[i] && src_q[i].size() > 0;
      {in_flit[i].last, in_flit[i].data} = src_q[i].size() > 0 ? src_q[i][0] : 17'h0;
    end
  endtask

  task automatic step();
    logic [1:0]  f;
    logic        of;
    logic [16:0] ov, d;
    #2;
    for (int i = 0; i < 2; i++) f[i] = in_flit[i].valid && in_ready[i];
    of = out_flit.valid && out_ready;
    ov = {out_flit.last, out_flit.data};
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (f[i]) d = src_q[i].pop_front();
    if (of) obs.push_back(ov);
    drive();
  endtask

  task automatic run(output int c);
    c = 0;
    while ((src_q[0].size() + src_q[1].size() > 0 || out_flit.valid) && c < 200) begin
      step();
      c++;
    end
    chk("drain", (src_q[0].size() + src_q[1].size() > 0) || out_flit.valid, 0);
  endtask

  task automatic pkt(input int i, input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) src_q[i].push_back({k == n - 1, base + 16'(k)});
  endtask

  task automatic exp_pkt(input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({k == n - 1, base + 16'(k)});
  endtask

  task automatic cmp_obs(input string tag);
    chk({tag, "_len"}, obs.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k < obs.size()) chk(tag, obs[k], exp_q[k]);
    obs.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_debug = 1'b1;
    en = '{1'b0, 1'b0};
    src_q[0].delete();
    src_q[1].delete();
    drive();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_debug = 1'b0;
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    en = '{1'b0, 1'b0};
    drive();
    #1 rst_debug = 1'b1;
    #1;
    chk("rst_valid", out_flit.valid, 0);
    chk("rst_last", out_flit.last, 0);
    chk("rst_data", out_flit.data, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_lenerr", len_error, 0);
    @(negedge clk);
    rst_debug = 1'b0;

    // single source, latency and throughput
    out_ready = 1'b1;
    pkt(0, 16'hA000, 4);
    en[0] = 1'b1;
    drive();
    #1;
    chk("s1_ready", in_ready, 2'b01);
    step();
    chk("s1_latency", out_flit, {1'b1, 1'b0, 16'hA000});
    chk("s1_grant", grant_idx, 0);
    run(cyc);
    chk("s1_cycles", cyc + 1, 5);
    exp_pkt(16'hA000, 4);
    cmp_obs("s1_data");
    chk("s1_lenerr", len_error, 0);

    // contention: no interleave, then rr_ptr wraps back to input 0
    do_reset();
    pkt(0, 16'hB000, 3);
    pkt(1, 16'hC000, 3);
    en = '{1'b1, 1'b1};
    drive();
    run(cyc);
    exp_pkt(16'hB000, 3);
    exp_pkt(16'hC000, 3);
    cmp_obs("s2_order");
    chk("s2_grant", grant_idx, 1);
    pkt(0, 16'hD000, 1);
    pkt(1, 16'hD100, 1);
    drive();
    run(cyc);
    exp_pkt(16'hD000, 1);
    exp_pkt(16'hD100, 1);
    cmp_obs("s2_wrap");

    // fairness
    do_reset();
    pkt(0, 16'hE000, 2);
    pkt(0, 16'hE010, 2);
    pkt(1, 16'hF000, 2);
    en = '{1'b1, 1'b1};
    drive();
    run(cyc);
    exp_pkt(16'hE000, 2);
    exp_pkt(16'hF000, 2);
    exp_pkt(16'hE010, 2);
    cmp_obs("s3_fair");

    // backpressure
    do_reset();
    out_ready = 1'b0;
    pkt(0, 16'h9000, 6);
    en[0] = 1'b1;
    drive();
    repeat (5) step();
    chk("s4_ready", in_ready, 0);
    chk("s4_hold", out_flit, {1'b1, 1'b0, 16'h9000});
    chk("s4_nopop", obs.size(), 0);
    chk("s4_left", src_q[0].size(), 4);
    out_ready = 1'b1;
    run(cyc);
    exp_pkt(16'h9000, 6);
    cmp_obs("s4_data");

    // length watchdog
    do_reset();
    for (int k = 0; k < 14; k++) begin
      src_q[0].push_back({k == 13, 16'h7000 + 16'(k)});
      exp_q.push_back({k == 11 || k == 13, 16'h7000 + 16'(k)});
    end
    en[0] = 1'b1;
    drive();
    run(cyc);
    cmp_obs("s5_wd");
    chk("s5_lenerr", len_error, 1);

    // async reset while locked with a full FIFO
    do_reset();
    out_ready = 1'b0;
    pkt(0, 16'h5000, 5);
    en[0] = 1'b1;
    drive();
    repeat (3) step();
    chk("s6_full", out_flit.valid, 1);
    chk("s6_lenerr", len_error, 0);
    pkt(1, 16'h6000, 2);
    en[1] = 1'b1;
    drive();
    #2 rst_debug = 1'b1;
    #1;
    chk("s6_async_valid", out_flit.valid, 0);
    chk("s6_async_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("s6_held_valid", out_flit.valid, 0);
    @(negedge clk);
    src_q[0].delete();
    en[0] = 1'b0;
    drive();
    rst_debug = 1'b0;
    out_ready = 1'b1;
    obs.delete();
    #1;
    chk("s6_ready", in_ready, 2'b10);
    step();
    chk("s6_grant", grant_idx, 1);
    run(cyc);
    exp_pkt(16'h6000, 2);
    cmp_obs("s6_data");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
